// File: rtl/core_pkg.sv
// core_pkg: shared RV32I core types and constants.
package core_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry {instr, pc, valid} holding register for a word returned while decode stalls.
module fetch_skid_buf
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic            unload_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic            valid_o
);
    logic [XLEN-1:0] instr_q, pc_q;
    logic            valid_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
            valid_q <= 1'b1;
        end else if (unload_i) begin
            valid_q <= 1'b0;
        end
    end
    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;
endmodule

// File: rtl/fetch.sv
// fetch: RV32I instruction fetch stage; owns the pc, issues single-outstanding word reads
// and presents one instruction at a time to decode, with redirect and wrong-path discard.
module fetch #(
    parameter logic [core_pkg::XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [core_pkg::XLEN-1:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      redirect,
    input  logic [core_pkg::XLEN-1:0] redirect_pc,
    output logic                      imem_req,
    output logic [core_pkg::XLEN-1:0] imem_addr,
    input  logic                      imem_ready,
    input  logic [core_pkg::XLEN-1:0] imem_data,
    input  logic                      imem_data_valid,
    output logic [core_pkg::XLEN-1:0] instr,
    output logic [core_pkg::XLEN-1:0] instr_pc,
    output logic                      instr_valid
);
    import core_pkg::*;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, instr_q, instr_d, ipc_q, ipc_d;
    logic            valid_q, valid_d, discard_q, discard_d;
    logic            skid_load, skid_unload, skid_flush, skid_valid, busy;
    logic [XLEN-1:0] skid_instr, skid_pc;

    fetch_skid_buf u_skid (
        .clk      (clk),
        .reset    (reset),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .flush_i  (skid_flush),
        .instr_i  (imem_data),
        .pc_i     (pc_q),
        .instr_o  (skid_instr),
        .pc_o     (skid_pc),
        .valid_o  (skid_valid)
    );

    // A response arriving in the redirect cycle retires the old request, so nothing is left to discard.
    assign busy = (state_q == WAIT && !imem_data_valid) || (state_q == REQ && imem_ready);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        discard_d   = discard_q;
        instr_d     = instr_q;
        ipc_d       = ipc_q;
        valid_d     = valid_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_flush  = 1'b0;
        if (valid_q && !stall) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end
        case (state_q)
            IDLE: state_d = REQ;
            REQ:  if (imem_ready) state_d = WAIT;
            WAIT: if (imem_data_valid) begin
                if (discard_q) begin
                    discard_d = 1'b0;
                    state_d   = REQ;
                end else begin
                    pc_d = pc_q + 32'd4;
                    if (!valid_q || !stall) begin
                        instr_d = imem_data;
                        ipc_d   = pc_q;
                        valid_d = 1'b1;
                        state_d = REQ;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = HOLD;
                    end
                end
            end
            HOLD: if (!stall) begin
                instr_d     = skid_instr;
                ipc_d       = skid_pc;
                valid_d     = skid_valid;
                skid_unload = 1'b1;
                state_d     = REQ;
            end
            default: state_d = IDLE;
        endcase
        if (redirect) begin
            pc_d        = redirect_pc & ~32'd3;
            instr_d     = NOP_INSTR;
            valid_d     = 1'b0;
            skid_flush  = 1'b1;
            skid_load   = 1'b0;
            skid_unload = 1'b0;
            discard_d   = busy;
            state_d     = busy ? WAIT : REQ;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            discard_q <= 1'b0;
            instr_q   <= NOP_INSTR;
            ipc_q     <= RESET_PC;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
            instr_q   <= instr_d;
            ipc_q     <= ipc_d;
            valid_q   <= valid_d;
        end
    end

    assign imem_req    = state_q == REQ;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;
    assign instr_valid = valid_q;
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed scoreboard bench for fetch; memory model answers one cycle after accept.
module tb_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic        clk = 0, reset = 1, stall = 0, redirect = 0, imem_ready = 0, imem_data_valid = 0;
    logic [31:0] redirect_pc = 0, imem_data = 0;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instr, instr_pc;
    bit          rdy_en = 0, mem_block = 0, pend = 0;
    logic [31:0] paddr = 0;
    int          compared = 0, mismatched = 0;
    logic [31:0] addr_q[$];
    logic [63:0] instr_q[$];

    fetch #(.RESET_PC(32'h100)) dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_data(imem_data),
        .imem_data_valid(imem_data_valid), .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic summary;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    endtask

    // Memory model: drives inputs at negedge; the accept monitor checks every accepted address.
    initial forever begin
        @(negedge clk);
        imem_data_valid = 0;
        if (pend && !mem_block) begin
            imem_data_valid = 1;
            imem_data = mk(paddr);
            pend = 0;
        end
        imem_ready = rdy_en;
        if (!reset && imem_req && imem_ready) begin
            pend = 1;
            paddr = imem_addr;
            if (addr_q.size() == 0) chk("unexpected_accept", imem_addr, 32'hFFFF_FFFF);
            else chk("accept_addr", imem_addr, addr_q.pop_front());
        end
    end

    // Delivery monitor: an instruction is consumed whenever valid and not stalled.
    initial forever begin
        @(negedge clk);
        if (!reset && instr_valid && !stall) begin
            if (instr_q.size() == 0) chk("unexpected_instr_pc", instr_pc, 32'hFFFF_FFFF);
            else begin
                logic [63:0] e;
                e = instr_q.pop_front();
                chk("instr", instr, e[63:32]);
                chk("instr_pc", instr_pc, e[31:0]);
            end
        end
    end

    initial begin
        #100000;
        mismatched++;
        $display("FAIL watchdog: got timeout expected completion");
        summary();
        $finish;
    end

    initial begin
        cyc(2);
        chk("rst_req", {31'b0, imem_req}, 0);
        chk("rst_addr", imem_addr, 32'h100);
        chk("rst_instr", instr, NOP);
        chk("rst_ipc", instr_pc, 32'h100);
        chk("rst_valid", {31'b0, instr_valid}, 0);
        addr_q = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h114};
        instr_q = '{{32'hDEAD0100, 32'h100}, {32'hDEAD0104, 32'h104}, {32'hDEAD0108, 32'h108},
                    {32'hDEAD010C, 32'h10C}, {32'hDEAD0110, 32'h110}};
        rdy_en = 1;
        reset = 0;
        chk("first_req_low", {31'b0, imem_req}, 0);
        cyc(1);
        chk("first_req_high", {31'b0, imem_req}, 1);
        for (int i = 0; i < 40 && !(instr_valid && instr_pc == 32'h10C); i++) cyc(1);
        chk("reach_10c_valid", {31'b0, instr_valid}, 1);
        chk("reach_10c_pc", instr_pc, 32'h10C);
        stall = 1;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("stall_pc", instr_pc, 32'h10C);
            chk("stall_instr", instr, 32'hDEAD010C);
            chk("stall_no_req", {31'b0, imem_req}, 0);
        end
        stall = 0;
        cyc(1);
        chk("unskid_pc", instr_pc, 32'h110);
        chk("unskid_valid", {31'b0, instr_valid}, 1);
        mem_block = 1;
        cyc(1);
        redirect = 1;
        redirect_pc = 32'h200;
        addr_q.push_back(32'h200);
        instr_q.push_back({32'hDEAD0200, 32'h200});
        cyc(1);
        redirect = 0;
        mem_block = 0;
        chk("redir_valid", {31'b0, instr_valid}, 0);
        chk("redir_instr", instr, NOP);
        chk("redir_wait", {31'b0, imem_req}, 0);
        cyc(1);
        chk("discard_valid", {31'b0, instr_valid}, 0);
        chk("discard_req", {31'b0, imem_req}, 1);
        chk("discard_addr", imem_addr, 32'h200);
        for (int i = 0; i < 20 && !(instr_valid && instr_pc == 32'h200); i++) cyc(1);
        chk("reach_200_pc", instr_pc, 32'h200);
        rdy_en = 0;
        cyc(1);
        chk("unaccepted_addr", imem_addr, 32'h204);
        redirect = 1;
        redirect_pc = 32'h203;
        cyc(1);
        chk("align_req", {31'b0, imem_req}, 1);
        chk("align_addr", imem_addr, 32'h200);
        redirect_pc = 32'hFFFF_FFFC;
        cyc(1);
        redirect = 0;
        chk("top_addr", imem_addr, 32'hFFFF_FFFC);
        addr_q.push_back(32'hFFFF_FFFC);
        addr_q.push_back(32'h0);
        instr_q.push_back({32'h2152FFFC, 32'hFFFF_FFFC});
        instr_q.push_back({32'hDEAD0000, 32'h0});
        rdy_en = 1;
        for (int i = 0; i < 20 && !(instr_valid && instr_pc == 32'h0); i++) cyc(1);
        chk("wrap_pc", instr_pc, 32'h0);
        chk("wrap_next_addr", imem_addr, 32'h4);
        mem_block = 1;
        addr_q.push_back(32'h4);
        cyc(1);
        chk("pre_reset_wait", {31'b0, imem_req}, 0);
        reset = 1;
        rdy_en = 0;
        #1;
        chk("mid_rst_req", {31'b0, imem_req}, 0);
        chk("mid_rst_addr", imem_addr, 32'h100);
        chk("mid_rst_valid", {31'b0, instr_valid}, 0);
        chk("mid_rst_instr", instr, NOP);
        cyc(1);
        reset = 0;
        mem_block = 0;
        cyc(1);
        chk("late_dv_valid", {31'b0, instr_valid}, 0);
        chk("late_dv_instr", instr, NOP);
        chk("post_rst_req", {31'b0, imem_req}, 1);
        chk("post_rst_addr", imem_addr, 32'h100);
        addr_q.push_back(32'h100);
        instr_q.push_back({32'hDEAD0100, 32'h100});
        rdy_en = 1;
        cyc(1);
        rdy_en = 0;
        for (int i = 0; i < 20 && !(instr_valid && instr_pc == 32'h100); i++) cyc(1);
        chk("post_rst_instr", instr, 32'hDEAD0100);
        cyc(3);
        chk("final_valid", {31'b0, instr_valid}, 0);
        chk("addr_q_empty", addr_q.size(), 0);
        chk("instr_q_empty", instr_q.size(), 0);
        summary();
        $finish;
    end
endmodule

// File: doc/fetch.md
# fetch

Instruction fetch stage of the in-order RV32I core. It sits directly upstream of `decode`: it owns the program counter and issues word reads to instruction memory over a request/valid handshake. It presents one instruction plus its PC to `decode` and holds it while `decode` raises `stall`. It also accepts PC redirects from branch/jump resolution and discards any wrong-path fetch in flight.

## Interface
- `RESET_PC`, default 32'h0000_0000, PC fetched first after reset.
- `NOP_INSTR`, default 32'h0000_0013 (addi x0,x0,0), driven on `instr` when no valid instruction is held; a known opcode, so `decode` does not stall on it.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `stall` in 1: from `decode`; current instruction not consumed this cycle.
- `redirect` in 1: one-cycle pulse, load new PC.
- `redirect_pc` in 32: redirect target; bits [1:0] are forced to 0.
- `imem_req` out 1: read request.
- `imem_addr` out 32: word address, stable while `imem_req`=1.
- `imem_ready` in 1: request accepted this cycle.
- `imem_data` in 32: returned instruction word.
- `imem_data_valid` in 1: `imem_data` valid this cycle.
- `instr` out 32: instruction to `decode`.
- `instr_pc` out 32: PC of `instr`.
- `instr_valid` out 1: `instr` is a real fetched instruction.

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD. At most one outstanding memory request.
- IDLE → REQ unconditionally on the first clock after reset release.
- REQ:
  - `imem_req`=1, `imem_addr`=pc.
  - On `imem_ready`, go to WAIT.
- WAIT:
  - `imem_req`=0.
  - On `imem_data_valid` with `discard`=1: drop the data, clear `discard`, go to REQ.
  - On `imem_data_valid` with the output register free (`instr_valid`=0 or `stall`=0): load {`imem_data`, pc} into the output register, set pc=pc+4, go to REQ.
  - Otherwise: load {`imem_data`, pc} into the skid register, set pc=pc+4, go to HOLD.
- HOLD: when `stall`=0, move the skid entry to the output register and go to REQ.
- Consumption: the output instruction is consumed in any cycle with `instr_valid`=1 and `stall`=0. If nothing replaces it, `instr_valid`←0 and `instr`←`NOP_INSTR`.
- Redirect has the highest priority over all other events in the same cycle:
  - pc←`redirect_pc` & ~3; `instr_valid`←0; `instr`←`NOP_INSTR`; skid entry invalidated.
  - If a request is outstanding (state WAIT, or REQ with `imem_ready`=1 this cycle): `discard`←1, next state WAIT.
  - Otherwise: next state REQ.
  - A redirect is never blocked by `stall`.
- pc arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- `imem_data_valid` outside WAIT is ignored.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `instr`=`NOP_INSTR`, `instr_pc`=`RESET_PC`, `instr_valid`=0, pc=`RESET_PC`, `discard`=0, state IDLE.
- First `imem_req` is asserted in the 2nd cycle after reset release.
- With zero wait states (`imem_ready`=1 and data valid the following cycle), one instruction is delivered every 2 cycles.
- Fetch latency: `instr_valid` rises the cycle after `imem_data_valid`.
- Redirect with no request outstanding: `imem_addr`=target with `imem_req`=1 in the next cycle.
- `imem_req`/`imem_addr` must not change until `imem_ready`. A redirect in REQ without `imem_ready` may retarget `imem_addr` (the request was not yet accepted).
- Reset asserted mid-operation returns everything to reset values immediately. A late `imem_data_valid` after reset release is ignored, because the FSM is not in WAIT.

## Structure
- `core_pkg`: `fetch_state_t` enum (IDLE, REQ, WAIT, HOLD), `NOP_INSTR` constant, `XLEN`=32.
- Sub-module `fetch_skid_buf`: one-entry {instr, pc, valid} register with load/unload/flush ports.
- The FSM, pc, `discard` flag and output register live in `fetch`.

## Test plan
- Reset with `RESET_PC`=32'h100, memory returns 1 cycle after accept → `imem_addr` sequence 100, 104, 108; `instr_valid` pulses carry `instr_pc` 100, 104, 108.
- Hold `stall`=1 for 5 cycles while data for 0x104 returns → `instr`/`instr_pc`=0x100 stable, 0x104 held in the skid buffer, no new `imem_req`; `stall`=0 → 0x104 presented the next cycle.
- `redirect`=1 with `redirect_pc`=32'h200 while in WAIT for 0x108 → returned 0x108 data discarded, `instr_valid`=0, next `imem_addr`=0x200.
- `redirect_pc`=32'h203 → `imem_addr`=0x200.
- PC at 32'hFFFF_FFFC → next `imem_addr`=0.
- Assert `reset` while in WAIT, then drive `imem_data_valid` after release → output stays `NOP_INSTR`, `instr_valid`=0; first request goes to `RESET_PC`.
